// File: rtl/spi_pkg.sv
// Shared types for the SPI master: FSM state encoding and bus mode.
package spi_pkg;

  localparam int unsigned SPI_MODE = 0;

  typedef enum logic [2:0] {
    IDLE,
    LOW,
    HIGH,
    WAIT,
    HOLD,
    GAP
  } spi_state_t;

endpackage

// File: rtl/spi_phase_timer.sv
// Loadable down-counter timing one SCK half-period; phase_end_c flags its last cycle.
module spi_phase_timer
  import spi_pkg::*;
#(
  parameter int unsigned clk_div = 2,
  localparam int unsigned PW = $clog2(clk_div + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  output logic [PW-1:0] count,
  output logic          phase_end_c
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= PW'(clk_div - 1);
    end else if (count != '0) begin
      count <= count - PW'(1);
    end
  end

  assign phase_end_c = (count == '0);

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI transmitter: valid/ready word input, MSB-first serialisation onto nCS/SCK/MOSI.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned width   = 8,
  parameter int unsigned clk_div = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [width-1:0] tx_data,
  input  logic             tx_last,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             nCS,
  output logic             SCK,
  output logic             MOSI,
  output logic             busy,
  output logic             word_done,
  output logic             xfer_done
);

  localparam int unsigned BW = $clog2(width + 1);
  localparam int unsigned PW = $clog2(clk_div + 1);

  spi_state_t       state;
  logic [width-1:0] sreg;
  logic [width-1:0] sreg_shift_c;
  logic             last_q;
  logic [BW-1:0]    bit_cnt;
  logic [PW-1:0]    phase_cnt;
  logic             phase_end_c;
  logic             accept_c;
  logic             timer_load_c;
  logic             word_done_c;

  assign accept_c     = tx_valid && tx_ready;
  assign sreg_shift_c = sreg << 1;

  // Reload the phase timer on every state change so each state starts a fresh half-period.
  always_comb begin
    timer_load_c = 1'b0;
    if (accept_c) begin
      timer_load_c = 1'b1;
    end else if (phase_end_c && (state == LOW || state == HIGH || state == HOLD)) begin
      timer_load_c = 1'b1;
    end
  end

  // word_done is registered, so it is raised one edge ahead of the final bit's last SCK-high cycle.
  always_comb begin
    word_done_c = 1'b0;
    if (bit_cnt == '0) begin
      if (clk_div > 1) begin
        word_done_c = (state == HIGH) && (phase_cnt == PW'(1));
      end else begin
        word_done_c = (state == LOW) && phase_end_c;
      end
    end
  end

  spi_phase_timer #(
    .clk_div(clk_div)
  ) u_phase_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load_c),
    .count      (phase_cnt),
    .phase_end_c(phase_end_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sreg      <= '0;
      last_q    <= 1'b0;
      bit_cnt   <= '0;
      nCS       <= 1'b1;
      SCK       <= 1'b0;
      MOSI      <= 1'b0;
      tx_ready  <= 1'b1;
      busy      <= 1'b0;
      word_done <= 1'b0;
      xfer_done <= 1'b0;
    end else begin
      word_done <= word_done_c;
      xfer_done <= 1'b0;
      case (state)
        IDLE, WAIT: begin
          if (accept_c) begin
            sreg     <= tx_data;
            last_q   <= tx_last;
            bit_cnt  <= BW'(width - 1);
            MOSI     <= tx_data[width-1];
            nCS      <= 1'b0;
            SCK      <= 1'b0;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= LOW;
          end
        end
        LOW: begin
          if (phase_end_c) begin
            SCK   <= 1'b1;
            state <= HIGH;
          end
        end
        HIGH: begin
          if (phase_end_c) begin
            SCK <= 1'b0;
            if (bit_cnt != '0) begin
              sreg    <= sreg_shift_c;
              MOSI    <= sreg_shift_c[width-1];
              bit_cnt <= bit_cnt - BW'(1);
              state   <= LOW;
            end else if (last_q) begin
              state <= HOLD;
            end else begin
              tx_ready <= 1'b1;
              state    <= WAIT;
            end
          end
        end
        HOLD: begin
          if (phase_end_c) begin
            nCS       <= 1'b1;
            xfer_done <= 1'b1;
            state     <= GAP;
          end
        end
        GAP: begin
          if (phase_end_c) begin
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: timing, back-to-back, stall, reset, edge parameters, loopback.
module tb_spi_master;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic [7:0]  a_data = '0;
  logic        a_last = 1'b0, a_valid = 1'b0;
  logic        a_ready, a_ncs, a_sck, a_mosi, a_busy, a_wd, a_xd;
  logic [15:0] b_data = '0;
  logic        b_last = 1'b0, b_valid = 1'b0;
  logic        b_ready, b_ncs, b_sck, b_mosi, b_busy, b_wd, b_xd;

  int checks = 0;
  int failures = 0;

  logic cap_ncs[0:127], cap_sck[0:127], cap_mosi[0:127];
  logic cap_rdy[0:127], cap_wd[0:127], cap_xd[0:127];

  int          d_rises, d_first_rise, d_wd_cnt, d_wd_pos, d_xd_cnt, d_xd_pos;
  int          d_ncs_low, d_ncs_rise, d_viol;
  logic [31:0] d_bits;
  int          d_rise_pos[0:31];

  // Bench-side receiver: samples MOSI on each SCK rise while nCS is low.
  logic       lb_en = 1'b0;
  logic [7:0] lb_sreg = '0;
  int         lb_bits = 0;
  int         lb_new_xfer = 0;
  logic [7:0] lb_rx[$];
  logic       lb_sck_prev = 1'b0, lb_ncs_prev = 1'b1;

  always #5 clk = ~clk;

  spi_master #(.width(8), .clk_div(2)) dut_a (
    .clk(clk), .reset(reset), .tx_data(a_data), .tx_last(a_last), .tx_valid(a_valid),
    .tx_ready(a_ready), .nCS(a_ncs), .SCK(a_sck), .MOSI(a_mosi), .busy(a_busy),
    .word_done(a_wd), .xfer_done(a_xd)
  );

  spi_master #(.width(16), .clk_div(1)) dut_b (
    .clk(clk), .reset(reset), .tx_data(b_data), .tx_last(b_last), .tx_valid(b_valid),
    .tx_ready(b_ready), .nCS(b_ncs), .SCK(b_sck), .MOSI(b_mosi), .busy(b_busy),
    .word_done(b_wd), .xfer_done(b_xd)
  );

  always @(posedge clk) begin
    if (!lb_en) begin
      lb_bits = 0;
      lb_new_xfer = 0;
      lb_rx.delete();
    end else begin
      if (lb_ncs_prev && !a_ncs) lb_new_xfer++;
      if (!a_ncs && a_sck && !lb_sck_prev) begin
        lb_sreg = {lb_sreg[6:0], a_mosi};
        lb_bits++;
        if (lb_bits == 8) begin
          lb_rx.push_back(lb_sreg);
          lb_bits = 0;
        end
      end
    end
    lb_sck_prev = a_sck;
    lb_ncs_prev = a_ncs;
  end

  task automatic sample(input int sel, input int k);
    if (sel == 0) begin
      cap_ncs[k] = a_ncs; cap_sck[k] = a_sck; cap_mosi[k] = a_mosi;
      cap_rdy[k] = a_ready; cap_wd[k] = a_wd; cap_xd[k] = a_xd;
    end else begin
      cap_ncs[k] = b_ncs; cap_sck[k] = b_sck; cap_mosi[k] = b_mosi;
      cap_rdy[k] = b_ready; cap_wd[k] = b_wd; cap_xd[k] = b_xd;
    end
  endtask

  task automatic cap_init();
    cap_ncs[0] = 1'b1; cap_sck[0] = 1'b0; cap_mosi[0] = 1'b0;
    cap_rdy[0] = 1'b1; cap_wd[0] = 1'b0; cap_xd[0] = 1'b0;
  endtask

  // Records cycles t+1 .. t+n after an accept edge t.
  task automatic capture(input int sel, input int n);
    cap_init();
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      sample(sel, k);
    end
  endtask

  // Waits (bounded) for tx_ready, then presents one word for exactly one accept edge.
  task automatic send(input int sel, input logic [15:0] data, input logic last);
    int   n;
    logic rdy;
    n = 0;
    forever begin
      @(negedge clk);
      rdy = (sel == 0) ? a_ready : b_ready;
      if (rdy || n >= 200) break;
      n++;
    end
    if (!rdy) begin
      checks++; failures++;
      $display("FAIL send_wait_ready sel=%0d: tx_ready=%b after %0d cycles, required 1", sel, rdy, n);
    end
    if (sel == 0) begin a_data = data[7:0]; a_last = last; a_valid = 1'b1; end
    else begin b_data = data; b_last = last; b_valid = 1'b1; end
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic decode(input int n);
    int hi;
    d_rises = 0; d_first_rise = -1; d_wd_cnt = 0; d_wd_pos = -1; d_xd_cnt = 0;
    d_xd_pos = -1; d_ncs_low = 0; d_ncs_rise = -1; d_viol = 0; d_bits = '0;
    for (int k = 1; k <= n; k++) begin
      if (cap_sck[k] && !cap_sck[k-1]) begin
        if (d_rises < 32) d_rise_pos[d_rises] = k;
        if (d_first_rise < 0) d_first_rise = k;
        d_rises++;
        d_bits = {d_bits[30:0], cap_mosi[k]};
      end
      if (k >= 2 && cap_mosi[k] !== cap_mosi[k-1] && cap_sck[k]) d_viol++;
      if (cap_wd[k]) begin d_wd_cnt++; if (d_wd_pos < 0) d_wd_pos = k; end
      if (cap_xd[k]) begin d_xd_cnt++; if (d_xd_pos < 0) d_xd_pos = k; end
      if (!cap_ncs[k]) d_ncs_low++;
      if (cap_ncs[k] && !cap_ncs[k-1] && d_ncs_rise < 0) d_ncs_rise = k;
    end
    hi = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({a_ncs, a_sck, a_mosi, a_ready, a_busy, a_wd, a_xd} !== 7'b1001000) begin
      failures++;
      $display("FAIL reset_a: {ncs,sck,mosi,rdy,busy,wd,xd}=%b required 1001000",
               {a_ncs, a_sck, a_mosi, a_ready, a_busy, a_wd, a_xd});
    end
    checks++;
    if ({b_ncs, b_sck, b_mosi, b_ready, b_busy, b_wd, b_xd} !== 7'b1001000) begin
      failures++;
      $display("FAIL reset_b: {ncs,sck,mosi,rdy,busy,wd,xd}=%b required 1001000",
               {b_ncs, b_sck, b_mosi, b_ready, b_busy, b_wd, b_xd});
    end
    #1 reset = 1'b0;
  endtask

  task automatic test_single_word();
    int bad_hi, run;
    send(0, 16'h00A5, 1'b1);
    capture(0, 40);
    decode(40);
    checks++;
    if (cap_ncs[1] !== 1'b0) begin failures++; $display("FAIL single_ncs_fall: ncs@t+1=%b required 0", cap_ncs[1]); end
    checks++;
    if (d_first_rise != 3) begin failures++; $display("FAIL single_first_rise: at t+%0d required t+3", d_first_rise); end
    checks++;
    if (d_rises != 8 || d_bits[7:0] !== 8'hA5) begin
      failures++; $display("FAIL single_bits: rises=%0d bits=%h required 8 / a5", d_rises, d_bits[7:0]);
    end
    bad_hi = 0; run = 0;
    for (int k = 1; k <= 40; k++) begin
      if (cap_sck[k]) run++;
      else begin if (run != 0 && run != 2) bad_hi++; run = 0; end
    end
    checks++;
    if (bad_hi != 0) begin failures++; $display("FAIL single_sck_high_width: %0d pulses not 2 cycles wide, required 0", bad_hi); end
    checks++;
    if (d_wd_cnt != 1 || d_wd_pos != 32) begin
      failures++; $display("FAIL single_word_done: count=%0d pos=t+%0d required 1 at t+32", d_wd_cnt, d_wd_pos);
    end
    checks++;
    if (d_ncs_rise != 35 || d_xd_cnt != 1 || d_xd_pos != 35) begin
      failures++;
      $display("FAIL single_ncs_rise: ncs rise t+%0d xfer_done cnt=%0d pos=t+%0d required t+35 / 1 / t+35",
               d_ncs_rise, d_xd_cnt, d_xd_pos);
    end
    checks++;
    if (cap_rdy[1] !== 1'b0 || cap_rdy[36] !== 1'b0 || cap_rdy[37] !== 1'b1) begin
      failures++;
      $display("FAIL single_tx_ready: rdy@t+1=%b @t+36=%b @t+37=%b required 0 0 1", cap_rdy[1], cap_rdy[36], cap_rdy[37]);
    end
    checks++;
    if (d_viol != 0) begin failures++; $display("FAIL single_mosi_stable: %0d changes while SCK high, required 0", d_viol); end
  endtask

  task automatic test_back_to_back();
    int lowgap;
    @(negedge clk);
    a_data = 8'h3C; a_last = 1'b0; a_valid = 1'b1;
    @(posedge clk);
    #1;
    a_data = 8'hC3; a_last = 1'b1;
    cap_init();
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      sample(0, k);
      if (k >= 2 && a_ready && a_valid) begin
        @(posedge clk);
        #1 a_valid = 1'b0;
      end
    end
    a_valid = 1'b0;
    decode(80);
    checks++;
    if (d_rises != 16 || d_bits[15:0] !== 16'h3CC3) begin
      failures++; $display("FAIL b2b_bits: rises=%0d bits=%h required 16 / 3cc3", d_rises, d_bits[15:0]);
    end
    checks++;
    if (d_ncs_low != 67 || d_ncs_rise != 68) begin
      failures++; $display("FAIL b2b_ncs_low: low cycles=%0d rise t+%0d required 67 / t+68", d_ncs_low, d_ncs_rise);
    end
    checks++;
    if (d_wd_cnt != 2 || d_xd_cnt != 1) begin
      failures++; $display("FAIL b2b_done_counts: word_done=%0d xfer_done=%0d required 2 / 1", d_wd_cnt, d_xd_cnt);
    end
    lowgap = 0;
    if (d_rises >= 9) begin
      for (int k = d_rise_pos[7] + 1; k < d_rise_pos[8]; k++) if (!cap_sck[k]) lowgap++;
    end
    checks++;
    if (lowgap != 3) begin failures++; $display("FAIL b2b_sck_low_gap: %0d cycles, required 3", lowgap); end
  endtask

  task automatic test_stall_wait();
    send(0, 16'h000F, 1'b0);
    capture(0, 42);
    decode(42);
    checks++;
    if (d_rises != 8 || d_bits[7:0] !== 8'h0F) begin
      failures++; $display("FAIL stall_first_bits: rises=%0d bits=%h required 8 / 0f", d_rises, d_bits[7:0]);
    end
    for (int k = 33; k <= 42; k++) begin
      checks++;
      if ({cap_ncs[k], cap_sck[k], cap_mosi[k], cap_rdy[k]} !== 4'b0011) begin
        failures++;
        $display("FAIL stall_wait_t+%0d: {ncs,sck,mosi,rdy}=%b required 0011", k,
                 {cap_ncs[k], cap_sck[k], cap_mosi[k], cap_rdy[k]});
      end
    end
    send(0, 16'h00F0, 1'b1);
    capture(0, 40);
    decode(40);
    checks++;
    if (d_rises != 8 || d_bits[7:0] !== 8'hF0 || d_xd_cnt != 1 || d_ncs_rise != 35) begin
      failures++;
      $display("FAIL stall_second_word: rises=%0d bits=%h xfer_done=%0d ncs rise t+%0d required 8 / f0 / 1 / t+35",
               d_rises, d_bits[7:0], d_xd_cnt, d_ncs_rise);
    end
  endtask

  task automatic test_reset_mid_word();
    int pulses;
    send(0, 16'h00FF, 1'b1);
    repeat (15) @(negedge clk);
    checks++;
    if (a_sck !== 1'b1) begin failures++; $display("FAIL rst_mid_in_high: sck=%b at t+15 required 1", a_sck); end
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_ncs, a_sck, a_mosi, a_ready, a_busy, a_wd, a_xd} !== 7'b1001000) begin
      failures++;
      $display("FAIL rst_mid_state: {ncs,sck,mosi,rdy,busy,wd,xd}=%b required 1001000",
               {a_ncs, a_sck, a_mosi, a_ready, a_busy, a_wd, a_xd});
    end
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (a_wd || a_xd || !a_ncs) pulses++;
    end
    checks++;
    if (pulses != 0) begin failures++; $display("FAIL rst_mid_quiet: %0d cycles with done pulse or ncs low, required 0", pulses); end
    send(0, 16'h005A, 1'b1);
    capture(0, 40);
    decode(40);
    checks++;
    if (d_rises != 8 || d_bits[7:0] !== 8'h5A || d_xd_cnt != 1) begin
      failures++;
      $display("FAIL rst_mid_after: rises=%0d bits=%h xfer_done=%0d required 8 / 5a / 1", d_rises, d_bits[7:0], d_xd_cnt);
    end
  endtask

  task automatic test_edge_params();
    send(1, 16'h8001, 1'b1);
    capture(1, 40);
    decode(40);
    checks++;
    if (d_rises != 16 || d_bits[15:0] !== 16'h8001) begin
      failures++; $display("FAIL edge_bits: rises=%0d bits=%h required 16 / 8001", d_rises, d_bits[15:0]);
    end
    checks++;
    if (d_ncs_low != 33 || d_first_rise != 2) begin
      failures++; $display("FAIL edge_ncs_low: low=%0d first rise t+%0d required 33 / t+2", d_ncs_low, d_first_rise);
    end
    checks++;
    if (d_wd_pos != 32 || d_xd_pos != 34 || d_viol != 0) begin
      failures++;
      $display("FAIL edge_done: word_done t+%0d xfer_done t+%0d mosi viol=%0d required t+32 / t+34 / 0",
               d_wd_pos, d_xd_pos, d_viol);
    end
  endtask

  task automatic test_loopback();
    logic [7:0] sent[$];
    logic [7:0] w;
    @(negedge clk);
    lb_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w = 8'($urandom);
      sent.push_back(w);
      send(0, {8'h00, w}, (i != 1));
    end
    send(0, 16'h0000, 1'b0);
    a_valid = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if (lb_rx.size() != 5) begin
      failures++; $display("FAIL loop_word_count: received %0d required 5", lb_rx.size());
    end
    for (int i = 0; i < 4 && i < lb_rx.size(); i++) begin
      checks++;
      if (lb_rx[i] !== sent[i]) begin
        failures++; $display("FAIL loop_word_%0d: received %h required %h", i, lb_rx[i], sent[i]);
      end
    end
    checks++;
    if (lb_new_xfer != 4) begin
      failures++; $display("FAIL loop_new_transfer: %0d assertions required 4", lb_new_xfer);
    end
    lb_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_stall_wait();
    test_reset_mid_word();
    test_edge_params();
    test_loopback();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
